// File: rtl/avl_burst_arbiter_pkg.sv
// Shared types and defaults for the two-port Avalon-MM burst arbiter.
// Tag FIFO entries record which port owns each outstanding read burst.
package avl_burst_arbiter_pkg;

    localparam int DW_DEF        = 64;
    localparam int AW_DEF        = 29;
    localparam int BW_DEF        = 8;
    localparam int TAG_DEPTH_DEF = 4;

    // Tag burstcount field is wide enough for any BW up to 16 bits.
    localparam int TAG_BC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_CMD   = 2'd1,
        ST_WR_BURST = 2'd2
    } state_t;

    typedef struct packed {
        logic                port;
        logic [TAG_BC_W-1:0] burstcount;
    } tag_t;

endpackage

// File: rtl/avl_rd_tag_fifo.sv
// Synchronous tag FIFO with a combinational head; a push and a pop in the
// same cycle both take effect, even when full.
module avl_rd_tag_fifo
    import avl_burst_arbiter_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  tag_t push_data,
    input  logic pop,
    output tag_t head,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q;
    logic [PW:0] rd_ptr_q;
    tag_t        mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/avl_burst_arbiter.sv
// Two-port round-robin Avalon-MM burst arbiter onto one shared master.
// Reads are tagged so returning data is steered back to the issuing port.
module avl_burst_arbiter
    import avl_burst_arbiter_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int BW        = BW_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic [AW-1:0]   s0_address,
    input  logic [BW-1:0]   s0_burstcount,
    input  logic            s0_read,
    input  logic            s0_write,
    input  logic [DW-1:0]   s0_writedata,
    input  logic [DW/8-1:0] s0_byteenable,
    output logic            s0_waitrequest,
    output logic [DW-1:0]   s0_readdata,
    output logic            s0_readdatavalid,

    input  logic [AW-1:0]   s1_address,
    input  logic [BW-1:0]   s1_burstcount,
    input  logic            s1_read,
    input  logic            s1_write,
    input  logic [DW-1:0]   s1_writedata,
    input  logic [DW/8-1:0] s1_byteenable,
    output logic            s1_waitrequest,
    output logic [DW-1:0]   s1_readdata,
    output logic            s1_readdatavalid,

    output logic [AW-1:0]   m_address,
    output logic [BW-1:0]   m_burstcount,
    output logic            m_read,
    output logic            m_write,
    output logic [DW-1:0]   m_writedata,
    output logic [DW/8-1:0] m_byteenable,
    input  logic            m_waitrequest,
    input  logic [DW-1:0]   m_readdata,
    input  logic            m_readdatavalid,

    output logic [1:0]      grant,
    output logic            rd_orphan
);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [BW-1:0] wr_cnt_q, wr_cnt_d;
    logic [BW-1:0] rd_cnt_q, rd_cnt_d;
    logic          orphan_q, orphan_d;

    logic [1:0]      rd_in, wr_in;
    logic [AW-1:0]   addr_in  [2];
    logic [BW-1:0]   bc_in    [2];
    logic [DW-1:0]   wdata_in [2];
    logic [DW/8-1:0] be_in    [2];
    logic [1:0]      rd_req, wr_req, req;
    logic [1:0]      wait_out, rdv_out;

    logic          winner;
    logic [BW-1:0] bc_eff;
    logic [BW-1:0] wr_base;
    logic [BW-1:0] rd_base;
    logic          ret_beat;
    logic          tag_push, tag_pop;
    tag_t          push_tag, head_tag;
    logic          fifo_full, fifo_empty;

    assign rd_in       = {s1_read, s0_read};
    assign wr_in       = {s1_write, s0_write};
    assign addr_in[0]  = s0_address;
    assign addr_in[1]  = s1_address;
    assign bc_in[0]    = s0_burstcount;
    assign bc_in[1]    = s1_burstcount;
    assign wdata_in[0] = s0_writedata;
    assign wdata_in[1] = s1_writedata;
    assign be_in[0]    = s0_byteenable;
    assign be_in[1]    = s1_byteenable;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // A read only counts as a request while there is a free tag.
            assign rd_req[gi]   = rd_in[gi] & ~fifo_full;
            assign wr_req[gi]   = wr_in[gi];
            assign req[gi]      = rd_req[gi] | wr_req[gi];
            assign wait_out[gi] = ~((state_q != ST_IDLE) && (owner_q == 1'(gi))) | m_waitrequest;
            assign rdv_out[gi]  = m_readdatavalid & ~fifo_empty & (head_tag.port == 1'(gi));
        end
    endgenerate

    assign s0_waitrequest   = wait_out[0];
    assign s1_waitrequest   = wait_out[1];
    assign s0_readdatavalid = rdv_out[0];
    assign s1_readdatavalid = rdv_out[1];
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;

    // On a tie the port that was not granted last wins.
    assign winner = (req[0] & req[1]) ? ~last_q : req[1];

    assign m_address    = addr_in[owner_q];
    assign m_burstcount = bc_in[owner_q];
    assign m_writedata  = wdata_in[owner_q];
    assign m_byteenable = be_in[owner_q];
    assign m_read       = (state_q == ST_RD_CMD)   & rd_in[owner_q];
    assign m_write      = (state_q == ST_WR_BURST) & wr_in[owner_q];

    assign bc_eff  = (bc_in[owner_q] == '0) ? BW'(1) : bc_in[owner_q];
    // A zero write counter means the first beat has not been accepted yet.
    assign wr_base = (wr_cnt_q == '0) ? bc_eff : wr_cnt_q;

    assign push_tag.port       = owner_q;
    assign push_tag.burstcount = TAG_BC_W'(bc_eff);

    assign grant     = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign rd_orphan = orphan_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        wr_cnt_d = wr_cnt_q;
        tag_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_cnt_d = '0;
                if (|req) begin
                    owner_d = winner;
                    last_d  = winner;
                    state_d = rd_req[winner] ? ST_RD_CMD : ST_WR_BURST;
                end
            end
            ST_RD_CMD: begin
                if (m_read && !m_waitrequest) begin
                    tag_push = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_WR_BURST: begin
                if (m_write && !m_waitrequest) begin
                    wr_cnt_d = wr_base - BW'(1);
                    if (wr_base == BW'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Return path: a zero counter means the head burst has not started yet.
    assign ret_beat = m_readdatavalid & ~fifo_empty;
    assign rd_base  = (rd_cnt_q == '0) ? BW'(head_tag.burstcount) : rd_cnt_q;
    assign tag_pop  = ret_beat & (rd_base == BW'(1));

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        orphan_d = orphan_q | (m_readdatavalid & fifo_empty);
        if (ret_beat) rd_cnt_d = rd_base - BW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            orphan_q <= orphan_d;
        end
    end

    avl_rd_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (tag_push),
        .push_data(push_tag),
        .pop      (tag_pop),
        .head     (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_avl_burst_arbiter.sv
// Scoreboard bench for avl_burst_arbiter: stimulus queues expected master
// beats and read returns, a negedge monitor pops and compares them.
module tb_avl_burst_arbiter;

    localparam int DW = 64;
    localparam int AW = 29;
    localparam int BW = 8;
    localparam int TAG_DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]   addr_a  [2];
    logic [BW-1:0]   bc_a    [2];
    logic            rd_a    [2];
    logic            wr_a    [2];
    logic [DW-1:0]   wd_a    [2];
    logic [DW/8-1:0] be_a    [2];
    logic            s0_waitrequest, s1_waitrequest;
    logic            s0_readdatavalid, s1_readdatavalid;
    logic [DW-1:0]   s0_readdata, s1_readdata;
    logic [1:0]      wait_a;

    logic [AW-1:0]   m_address;
    logic [BW-1:0]   m_burstcount;
    logic            m_read, m_write;
    logic [DW-1:0]   m_writedata;
    logic [DW/8-1:0] m_byteenable;
    logic            m_waitrequest = 1'b0;
    logic [DW-1:0]   m_readdata = '0;
    logic            m_readdatavalid = 1'b0;
    logic [1:0]      grant;
    logic            rd_orphan;

    assign wait_a = {s1_waitrequest, s0_waitrequest};

    avl_burst_arbiter #(.DW(DW), .AW(AW), .BW(BW), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_address(addr_a[0]), .s0_burstcount(bc_a[0]), .s0_read(rd_a[0]), .s0_write(wr_a[0]),
        .s0_writedata(wd_a[0]), .s0_byteenable(be_a[0]), .s0_waitrequest(s0_waitrequest),
        .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(addr_a[1]), .s1_burstcount(bc_a[1]), .s1_read(rd_a[1]), .s1_write(wr_a[1]),
        .s1_writedata(wd_a[1]), .s1_byteenable(be_a[1]), .s1_waitrequest(s1_waitrequest),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .grant(grant), .rd_orphan(rd_orphan)
    );

    typedef struct {
        bit              wr;
        logic [AW-1:0]   addr;
        logic [BW-1:0]   bc;
        logic [DW-1:0]   data;
        logic [1:0]      gnt;
        bit              gap;
    } m_exp_t;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } r_exp_t;

    m_exp_t exp_m[$];
    r_exp_t exp_r[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue the master-side beats a command should produce; write data steps by one per beat.
    function automatic void push_m(bit wr, logic [AW-1:0] a, logic [BW-1:0] bc,
                                   logic [DW-1:0] d0, int p, bit gap);
        int beats;
        m_exp_t e;
        beats = wr ? ((bc == 0) ? 1 : int'(bc)) : 1;
        for (int i = 0; i < beats; i++) begin
            e.wr = wr; e.addr = a; e.bc = bc; e.data = d0 + DW'(i);
            e.gnt = (p == 1) ? 2'b10 : 2'b01;
            e.gap = gap && (i == 0);
            exp_m.push_back(e);
        end
    endfunction

    function automatic void push_r(int p, logic [DW-1:0] d0, int n);
        r_exp_t r;
        for (int i = 0; i < n; i++) begin
            r.port = (p == 1);
            r.data = d0 + DW'(i);
            exp_r.push_back(r);
        end
    endfunction

    // Requester model: holds the command until every beat is accepted.
    task automatic req(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] bc, input logic [DW-1:0] d0);
        int beats, done, guard;
        bit w;
        beats = rd ? 1 : ((bc == 0) ? 1 : int'(bc));
        addr_a[p] = a; bc_a[p] = bc; rd_a[p] = rd; wr_a[p] = wr;
        wd_a[p] = d0; be_a[p] = d0[DW/8-1:0];
        done = 0; guard = 0;
        while (done < beats && guard < 300) begin
            @(negedge clk);
            w = wait_a[p];
            @(posedge clk);
            #1;
            guard++;
            if (!w) begin
                done++;
                wd_a[p] = d0 + DW'(done);
                be_a[p] = wd_a[p][DW/8-1:0];
            end
        end
        check($sformatf("req_done_p%0d", p), 128'(done), 128'(beats));
        rd_a[p] = 1'b0; wr_a[p] = 1'b0;
    endtask

    task automatic mem_ret(input int n, input logic [DW-1:0] d0);
        for (int i = 0; i < n; i++) begin
            m_readdatavalid = 1'b1;
            m_readdata = d0 + DW'(i);
            @(posedge clk);
            #1;
        end
        m_readdatavalid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 128'(grant), 128'(2'b00));
        check({tag, "_wait"}, 128'({s1_waitrequest, s0_waitrequest}), 128'(2'b11));
        check({tag, "_mrw"}, 128'({m_read, m_write}), 128'(2'b00));
        check({tag, "_rdv"}, 128'({s1_readdatavalid, s0_readdatavalid}), 128'(2'b00));
        check({tag, "_orphan"}, 128'(rd_orphan), 128'(0));
    endtask

    // Monitor: every accepted master beat and every steered read beat is compared.
    initial begin
        m_exp_t e;
        r_exp_t r;
        logic [127:0] act, exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n) begin
                if ((m_read | m_write) && !m_waitrequest) begin
                    if (exp_m.size() == 0) begin
                        check("unexpected_m_beat", 128'({m_read, m_write, m_address}), 128'(0));
                    end else begin
                        e = exp_m.pop_front();
                        act = {m_write, m_read, m_address, m_burstcount,
                               m_write ? m_writedata : DW'(0),
                               m_write ? m_byteenable : (DW/8)'(0),
                               grant, s1_waitrequest, s0_waitrequest};
                        exp = {e.wr, ~e.wr, e.addr, e.bc,
                               e.wr ? e.data : DW'(0),
                               e.wr ? e.data[DW/8-1:0] : (DW/8)'(0),
                               e.gnt, ~e.gnt};
                        check("m_beat", act, exp);
                        if (e.gap) check("grant_gap", 128'(cyc - last_acc), 128'(2));
                        last_acc = cyc;
                    end
                end
                if (s0_readdatavalid | s1_readdatavalid) begin
                    if (exp_r.size() == 0) begin
                        check("unexpected_rdv", 128'({s1_readdatavalid, s0_readdatavalid}), 128'(0));
                    end else begin
                        r = exp_r.pop_front();
                        check("rd_ret",
                              {s1_readdatavalid, s0_readdatavalid, s0_readdata, s1_readdata},
                              {(r.port ? 2'b10 : 2'b01), r.data, r.data});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, guard;
        bit w;
        for (int i = 0; i < 2; i++) begin
            addr_a[i] = '0; bc_a[i] = '0; rd_a[i] = 1'b0; wr_a[i] = 1'b0;
            wd_a[i] = '0; be_a[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous write bursts: s0 wins the first tie, with a master stall mid-burst.
        push_m(1, AW'('h100), 8'd4, DW'('hA0), 0, 0);
        push_m(1, AW'('h200), 8'd2, DW'('hB0), 1, 0);
        fork
            req(0, 0, 1, AW'('h100), 8'd4, DW'('hA0));
            req(1, 0, 1, AW'('h200), 8'd2, DW'('hB0));
            begin
                repeat (2) @(posedge clk);
                #1 m_waitrequest = 1'b1;
                repeat (2) @(posedge clk);
                #1 m_waitrequest = 1'b0;
            end
        join

        // Two read bursts, five return beats steered 3 to s0 then 2 to s1.
        push_m(0, AW'('h300), 8'd3, '0, 0, 0);
        req(0, 1, 0, AW'('h300), 8'd3, '0);
        push_m(0, AW'('h340), 8'd2, '0, 1, 0);
        req(1, 1, 0, AW'('h340), 8'd2, '0);
        push_r(0, DW'('hD0), 3);
        push_r(1, DW'('hD3), 2);
        mem_ret(5, DW'('hD0));

        // Read wins over write on the same port; a write is then granted with a read outstanding.
        push_m(0, AW'('h400), 8'd2, '0, 1, 0);
        req(1, 1, 1, AW'('h400), 8'd2, DW'('h11));
        push_m(1, AW'('h480), 8'd2, DW'('hC8), 0, 0);
        req(0, 0, 1, AW'('h480), 8'd2, DW'('hC8));
        push_r(1, DW'('hE0), 2);
        mem_ret(2, DW'('hE0));

        // Return data with nothing outstanding is dropped and latches rd_orphan.
        check("orphan_before", 128'(rd_orphan), 128'(0));
        mem_ret(1, DW'('hEE));
        check("orphan_set", 128'(rd_orphan), 128'(1));
        repeat (3) @(posedge clk);
        #1 check("orphan_sticky", 128'(rd_orphan), 128'(1));

        // Fill all four tags (one with burstcount 0), then a fifth read must wait for a pop.
        push_m(0, AW'('h500), 8'd1, '0, 0, 0); req(0, 1, 0, AW'('h500), 8'd1, '0);
        push_m(0, AW'('h501), 8'd0, '0, 1, 0); req(1, 1, 0, AW'('h501), 8'd0, '0);
        push_m(0, AW'('h502), 8'd1, '0, 0, 0); req(0, 1, 0, AW'('h502), 8'd1, '0);
        push_m(0, AW'('h503), 8'd1, '0, 1, 0); req(1, 1, 0, AW'('h503), 8'd1, '0);
        push_m(0, AW'('h504), 8'd1, '0, 0, 0);
        push_r(0, DW'('h10), 1);
        fork
            req(0, 1, 0, AW'('h504), 8'd1, '0);
            begin
                repeat (6) begin
                    @(negedge clk);
                    check("full_wait", 128'({s0_waitrequest, grant}), 128'({1'b1, 2'b00}));
                end
                @(posedge clk); #1;
                mem_ret(1, DW'('h10));
            end
        join
        push_r(1, DW'('h20), 1);
        push_r(0, DW'('h21), 1);
        push_r(1, DW'('h22), 1);
        push_r(0, DW'('h23), 1);
        mem_ret(4, DW'('h20));

        // burstcount 0 write is one beat; reset mid-burst abandons the write and the pending tag.
        push_m(1, AW'('h600), 8'd0, DW'('h70), 0, 0);
        req(0, 0, 1, AW'('h600), 8'd0, DW'('h70));
        push_m(0, AW'('h610), 8'd1, '0, 1, 0);
        req(1, 1, 0, AW'('h610), 8'd1, '0);
        push_m(1, AW'('h620), 8'd4, DW'('h80), 0, 0);
        void'(exp_m.pop_back());
        void'(exp_m.pop_back());
        addr_a[0] = AW'('h620); bc_a[0] = 8'd4; wr_a[0] = 1'b1;
        wd_a[0] = DW'('h80); be_a[0] = 8'h80;
        beats = 0; guard = 0;
        while (beats < 2 && guard < 100) begin
            @(negedge clk);
            w = s0_waitrequest;
            @(posedge clk); #1;
            guard++;
            if (!w) begin
                beats++;
                wd_a[0] = DW'('h80) + DW'(beats);
                be_a[0] = wd_a[0][DW/8-1:0];
            end
        end
        check("pre_reset_beats", 128'(beats), 128'(2));
        reset_n = 1'b0;
        wr_a[0] = 1'b0;
        #1 check_reset_outputs("midburst_reset");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("held_reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        mem_ret(1, DW'('h77));
        check("orphan_after_reset", 128'(rd_orphan), 128'(1));
        push_m(1, AW'('h700), 8'd2, DW'('hC0), 1, 0);
        req(1, 0, 1, AW'('h700), 8'd2, DW'('hC0));

        // Continuous traffic from both ports: strict alternation, one idle cycle per grant.
        for (int i = 0; i < 50; i++) begin
            push_m(1, AW'('h1000 + i), 8'd1, DW'('h5000 + i), 0, (i != 0));
            push_m(1, AW'('h2000 + i), 8'd1, DW'('h6000 + i), 1, 1);
        end
        fork
            begin
                for (int i = 0; i < 50; i++) req(0, 0, 1, AW'('h1000 + i), 8'd1, DW'('h5000 + i));
            end
            begin
                for (int j = 0; j < 50; j++) req(1, 0, 1, AW'('h2000 + j), 8'd1, DW'('h6000 + j));
            end
        join

        repeat (5) @(posedge clk);
        #1;
        check("exp_m_drained", 128'(exp_m.size()), 128'(0));
        check("exp_r_drained", 128'(exp_r.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avl_burst_arbiter.md
AVL_BURST_ARBITER -- requirements
Module: avl_burst_arbiter

Interface
REQ-001 SHALL have parameter DW, default 64, meaning data width in bits; byteenable width is DW/8.
REQ-002 SHALL have parameter AW, default 29, meaning word address width.
REQ-003 SHALL have parameter BW, default 8, meaning burstcount width.
REQ-004 SHALL have parameter TAG_DEPTH, default 4, meaning the maximum number of outstanding read bursts (power of 2).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset is asynchronous and active-low.
REQ-007 SHALL have, for each N in {0,1}, the requester slave ports sN_address (in, AW), sN_burstcount (in, BW), sN_read (in, 1), sN_write (in, 1), sN_writedata (in, DW), sN_byteenable (in, DW/8), sN_waitrequest (out, 1), sN_readdata (out, DW) and sN_readdatavalid (out, 1).
REQ-008 SHALL have the shared master ports m_address (out, AW), m_burstcount (out, BW), m_read (out, 1), m_write (out, 1), m_writedata (out, DW), m_byteenable (out, DW/8), m_waitrequest (in, 1), m_readdata (in, DW) and m_readdatavalid (in, 1).
REQ-009 SHALL have port grant, output, 2: one-hot current owner, 0 when idle.
REQ-010 SHALL have port rd_orphan, output, 1: sticky flag set by read data that arrives with no outstanding burst.

Function
REQ-011 SHALL implement FSM states IDLE, RD_CMD and WR_BURST.
REQ-012 IDLE: a port requests when (read|write) is high; a read request counts only if the tag FIFO is not full; the winner is registered and the FSM moves to RD_CMD or WR_BURST on the next cycle (1-cycle arbitration latency).
REQ-013 Arbitration SHALL be round-robin: when both ports request, the port not granted last wins; a single requester always wins; the pointer resets to "port 1 last", so port 0 wins the first tie.
REQ-014 If a requester asserts both read and write in IDLE, read SHALL take priority.
REQ-015 In RD_CMD/WR_BURST, m_address, m_burstcount, m_read, m_write, m_writedata and m_byteenable SHALL be combinationally muxed from the granted port; the granted sN_waitrequest equals m_waitrequest.
REQ-016 The non-granted port's waitrequest, and both ports' waitrequest in IDLE, SHALL be 1; m_read and m_write SHALL be 0 in IDLE.
REQ-017 RD_CMD: on m_read & !m_waitrequest, SHALL push {port, burstcount} into the tag FIFO and return to IDLE.
REQ-018 WR_BURST: the first accepted beat loads the beat counter with burstcount-1; each later accepted beat decrements it; the accepted beat at count 0 returns the FSM to IDLE; the grant is never released mid-burst.
REQ-019 A burstcount of 0 SHALL be treated as 1 for both reads and writes, and 1 is the value pushed into the tag FIFO.
REQ-020 Read return: m_readdata SHALL be broadcast to s0_readdata and s1_readdata; sN_readdatavalid = m_readdatavalid & (head.port==N) & FIFO not empty, combinational with zero latency.
REQ-021 A return beat counter SHALL load from head.burstcount and count down on each m_readdatavalid; the last beat pops the head entry.
REQ-022 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-023 m_readdatavalid while the FIFO is empty SHALL be dropped, with no sN_readdatavalid, and SHALL set rd_orphan until reset.
REQ-024 New reads and writes MAY be granted while read data is still returning; write grants are never blocked by outstanding reads.

Reset
REQ-025 While reset_n=0: the FSM is IDLE, the tag FIFO is empty, all counters are 0, grant=0, rd_orphan=0, m_read=m_write=0, sN_waitrequest=1 and sN_readdatavalid=0.
REQ-026 Reset mid-burst SHALL abandon the burst immediately; outstanding tags are discarded and subsequent returns count as orphans.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the tag struct {port, burstcount}, and the defaults for DW, AW, BW and TAG_DEPTH.
REQ-028 The tag FIFO SHALL be the sub-module avl_rd_tag_fifo (sync FIFO with full/empty flags, simultaneous push/pop).

Verification
REQ-029 s0 write burst of 4 and s1 write burst of 2 requested in the same cycle -> s0 is granted first, all 4 beats pass on m_*, s1 waitrequest stays 1 throughout, then s1's 2 beats follow; grant sequence is 01,10.
REQ-030 s0 read burst of 3, then s1 read burst of 2, memory returns 5 beats -> s0 readdatavalid on beats 1-3 and s1 on beats 4-5; FIFO empty at the end.
REQ-031 Four reads of burstcount 1 with no returns (FIFO full) then a fifth read -> the fifth stays waitrequest=1 until the first return pops a tag, and is then granted.
REQ-032 m_readdatavalid with no outstanding reads -> no sN_readdatavalid and rd_orphan=1 until reset.
REQ-033 burstcount=0 write, then reset_n pulsed low during a 4-beat write at beat 2 -> a single beat is accepted for the burstcount=0 write; after the reset pulse, outputs match REQ-025 and the next request is granted normally.
REQ-034 Continuous requests from both ports for 100 commands -> grants alternate strictly with no starvation; a grant follows IDLE after exactly one cycle.
